// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM -> WB pipeline stage built as a 2-entry in-order buffer. The
//   write-back source is selected when an entry is pushed, so each slot holds
//   only {wb_data, wb_en, wb_dest}. in_ready depends on registered state only.
//   There is no combinational path from out_ready to in_ready.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   flush          synchronous flush; drops all held entries and any same-cycle push
//   in_valid/in_ready                         upstream handshake
//   in_alu_result, in_mem_data, in_wb_sel     write-back source candidates and select
//   in_wb_en, in_wb_dest                      register write enable / destination
//   out_valid/out_ready                       downstream handshake (head entry)
//   out_wb_data, out_wb_en, out_wb_dest       head entry contents
//   rf_we          register-file write strobe (out_valid & out_ready & out_wb_en)
//   fwd_valid      head entry will write a register (EX forwarding)
//   stall_cnt      saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic                  in_wb_en,
  input  logic [REG_ADDR_W-1:0] in_wb_dest,
  input  logic                  in_wb_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic                  out_wb_en,
  output logic [REG_ADDR_W-1:0] out_wb_dest,
  output logic                  rf_we,
  output logic                  fwd_valid,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [DATA_W-1:0]     data_q [2];
  logic                  en_q   [2];
  logic [REG_ADDR_W-1:0] dest_q [2];

  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;     // 0, 1 or 2 entries held
  logic                  live_q;      // set at the first edge after reset release
  logic [CNT_W-1:0]      stall_cnt_q;

  logic                  push;
  logic                  pop;
  logic [DATA_W-1:0]     wb_data_sel;

  // in_ready is held low during reset and until the first clock edge after
  // release. After that it is low only when both slots are occupied.
  assign in_ready    = live_q & ~count_q[1];
  assign out_valid   = (count_q != 2'd0);

  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;

  assign wb_data_sel = in_wb_sel ? in_mem_data : in_alu_result;

  assign out_wb_data = data_q[rd_ptr_q];
  assign out_wb_en   = en_q[rd_ptr_q];
  assign out_wb_dest = dest_q[rd_ptr_q];

  // A pop in a flush cycle still commits the head write to the register file.
  assign rf_we       = pop & out_wb_en;
  assign fwd_valid   = out_valid & out_wb_en;
  assign stall_cnt   = stall_cnt_q;

  // NOTE: the two storage slots are reset as well as the control state.
  // The head fields must read 0 while reset is low. With only two slots,
  // resetting them adds very little logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        en_q[i]   <= 1'b0;
        dest_q[i] <= '0;
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      live_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;

      if (flush) begin
        // Flush has priority over push and pop. The pointers return to a known origin.
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= wb_data_sel;
          en_q[wr_ptr_q]   <= in_wb_en;
          dest_q[wr_ptr_q] <= in_wb_dest;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        // A push is only possible below 2 entries and a pop only above 0.
        // The 2-bit count therefore never overflows or underflows.
        unique case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end

      // The stall counter records back-pressure history and keeps counting through a flush.
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
